// File: rtl/vga_capture.sv
`default_nettype none
// ============================================================================
//  Module   : vga_capture
//  Purpose  : Samples a parallel VGA-style pixel stream (pclk/hsync/vsync/de
//             plus R/G/B) and packs active pixels into 64-bit words of four
//             16-bit pixels. Words are queued in a small FIFO and delivered
//             on a valid/ready interface, each tagged with a start-of-frame
//             bit.
//  Ports    : clk_i, rst_i            - clock, async active-high reset
//             en_i, clr_i             - capture enable, status clear
//             mode_i                  - pixel format (332/444/555/565)
//             pclk_i, hsync_i,
//             vsync_i, de_i,
//             vga_r_i/g_i/b_i         - sampled video input
//             pixel_valid_o/ready_i,
//             pixel_data_o, sof_o     - packed-word output stream
//             overflow_o, frame_cnt_o - sticky drop flag, frame counter
//  Revision : 1.0 - initial release
// ============================================================================
module vga_capture #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [1:0]  mode_i,
    input  logic        pclk_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        de_i,
    input  logic [4:0]  vga_r_i,
    input  logic [5:0]  vga_g_i,
    input  logic [4:0]  vga_b_i,
    output logic        pixel_valid_o,
    input  logic        pixel_ready_i,
    output logic [63:0] pixel_data_o,
    output logic        sof_o,
    output logic        overflow_o,
    output logic [15:0] frame_cnt_o
);

    localparam int             c_AW      = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]  c_PTR_ONE = 1;
    localparam logic [c_AW:0]  c_FULL    = (c_AW+1)'(FIFO_DEPTH);

    // hsync carries no information for packing; kept only for port symmetry.
    logic w_unused_hsync;
    assign w_unused_hsync = hsync_i;

    // ------------------------------------------------------------------
    // Sample strobe on the pclk rising level transition
    // ------------------------------------------------------------------
    logic r_pclk_q;
    logic w_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_pclk_q <= 1'b0;
        else       r_pclk_q <= pclk_i;
    end

    assign w_s = en_i & pclk_i & ~r_pclk_q;

    // ------------------------------------------------------------------
    // Pixel repack, zero-extended to 16 bits
    // ------------------------------------------------------------------
    logic [15:0] w_pixel;

    always_comb begin
        w_pixel = '0;
        case (mode_i)
            2'd0:    w_pixel = {8'b0, vga_r_i[2:0], vga_g_i[2:0], vga_b_i[1:0]};
            2'd1:    w_pixel = {4'b0, vga_r_i[3:0], vga_g_i[3:0], vga_b_i[3:0]};
            2'd2:    w_pixel = {1'b0, vga_r_i, vga_g_i[4:0], vga_b_i};
            default: w_pixel = {vga_r_i, vga_g_i, vga_b_i};
        endcase
    end

    // ------------------------------------------------------------------
    // Pack state and push generation
    // ------------------------------------------------------------------
    logic [1:0]  r_lane;
    logic [47:0] r_hold;
    logic        r_prev_de;
    logic        r_prev_vs;
    logic        r_frame_pend;

    logic        w_vs_rise;
    logic        w_push;
    logic [63:0] w_push_data;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_wr_en;

    assign w_vs_rise = w_s & vsync_i & ~r_prev_vs;
    // Full word on the 4th pixel, or partial word when de falls mid-word.
    assign w_push    = w_s & ((de_i & (r_lane == 2'd3)) |
                              (~de_i & r_prev_de & (r_lane != 2'd0)));
    // Hold is cleared after every push, so unused lanes are already zero.
    assign w_push_data = de_i ? {w_pixel, r_hold} : {16'b0, r_hold};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lane       <= 2'd0;
            r_hold       <= '0;
            r_prev_de    <= 1'b0;
            r_prev_vs    <= 1'b0;
            r_frame_pend <= 1'b0;
        end else if (!en_i) begin
            r_lane       <= 2'd0;
            r_hold       <= '0;
            r_prev_de    <= 1'b0;
            r_prev_vs    <= 1'b0;
            r_frame_pend <= 1'b0;
        end else if (w_s) begin
            r_prev_de <= de_i;
            r_prev_vs <= vsync_i;
            if (w_push) begin
                r_lane <= 2'd0;
                r_hold <= '0;
            end else if (de_i) begin
                case (r_lane)
                    2'd0:    r_hold[15:0]  <= w_pixel;
                    2'd1:    r_hold[31:16] <= w_pixel;
                    default: r_hold[47:32] <= w_pixel;
                endcase
                r_lane <= r_lane + 2'd1;
            end
            // A new frame edge outranks consumption of the old pending tag.
            if (w_vs_rise)
                r_frame_pend <= 1'b1;
            else if (w_wr_en)
                r_frame_pend <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (pointers carry one extra wrap bit)
    // ------------------------------------------------------------------
    logic [64:0]   r_mem [FIFO_DEPTH];
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic [64:0]   w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = ((r_wr_ptr - r_rd_ptr) == c_FULL);
    assign w_pop   = ~w_empty & pixel_ready_i;
    // A pop in the same cycle frees the slot the push lands in.
    assign w_wr_en = w_push & (~w_full | w_pop);

    always_ff @(posedge clk_i) begin
        if (w_wr_en)
            r_mem[r_wr_ptr[c_AW-1:0]] <= {r_frame_pend, w_push_data};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (!en_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // Storage is not reset; gating with valid keeps outputs at zero when empty.
    assign w_head        = r_mem[r_rd_ptr[c_AW-1:0]];
    assign pixel_valid_o = ~w_empty;
    assign pixel_data_o  = w_empty ? 64'd0 : w_head[63:0];
    assign sof_o         = ~w_empty & w_head[64];

    // ------------------------------------------------------------------
    // Status: sticky overflow and frame counter; clear wins
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o  <= 1'b0;
            frame_cnt_o <= 16'd0;
        end else if (clr_i) begin
            overflow_o  <= 1'b0;
            frame_cnt_o <= 16'd0;
        end else begin
            if (w_push & w_full & ~w_pop) overflow_o  <= 1'b1;
            if (w_vs_rise)                frame_cnt_o <= frame_cnt_o + 16'd1;
        end
    end

endmodule
`default_nettype wire
